ex_stage_module: RTL and testbench
==================================

EX_STAGE_MODULE -- requirements
Module: ex_stage_module

Interface
REQ-001 SHALL have port clk, input, 1, the single rising-edge clock.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port freeze, input, 1, which holds the EX/MEM register and the status register.
REQ-004 SHALL have port pc_in, input, 32, the staged PC (already +4).
REQ-005 SHALL have ports mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in, input, 1 each, the staged ID controls.
REQ-006 SHALL have port execute_command_in, input, 4, the ALU opcode.
REQ-007 SHALL have ports reg_file_in1 and reg_file_in2, input, 32 each, the Rn and Rm values.
REQ-008 SHALL have ports dest_reg_in (4), signed_immediate_in (24) and shift_operand_in (12), all inputs.
REQ-009 SHALL have ports sel_src1 and sel_src2 (input, 2 each), mem_fwd_value (input, 32) and wb_fwd_value (input, 32), the forwarding inputs.
REQ-010 SHALL have port status_reg_out, output, 4, the NZCV register in bits [3:0], fed back to ID.
REQ-011 SHALL have ports branch_taken_out (output, 1) and branch_address_out (output, 32), combinational outputs to IF.
REQ-012 SHALL have registered outputs alu_result_out (32), store_value_out (32), dest_reg_out (4), mem_read_en_out, mem_write_en_out and wb_enable_out (1 each).

Function
REQ-013 SHALL compute operand A as follows: sel_src1 00 gives reg_file_in1; 01 gives mem_fwd_value; 10 gives wb_fwd_value; 11 gives reg_file_in1. Operand B (the Rm value) SHALL be selected the same way using sel_src2 and reg_file_in2.
REQ-014 SHALL generate Val2 when immediate_in=1 as the zero-extended shift_operand_in[7:0] rotated right by 2*shift_operand_in[11:8].
REQ-015 SHALL generate Val2, when immediate_in=0 and either memory enable is set, as the zero-extended shift_operand_in[11:0].
REQ-016 SHALL otherwise generate Val2 as operand B shifted by shift_operand_in[11:7], with type shift_operand_in[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift amount of 0 SHALL pass operand B unchanged.
REQ-017 SHALL decode execute_command_in as: 0001 MOV=Val2; 1001 MVN=~Val2; 0010 ADD=A+Val2; 0011 ADC=A+Val2+C; 0100 SUB=A-Val2; 0101 SBC=A+~Val2+C; 0110 AND; 0111 ORR; 1000 EOR. All other codes SHALL produce a result of 0 with no flag change.
REQ-018 SHALL compute flags as N=res[31] and Z=(res==0). For add/sub, C SHALL be the 33rd-bit carry (for subtraction, C=1 means no borrow) and V SHALL be signed overflow. For logical ops and MOV/MVN, C and V SHALL keep their current values.
REQ-019 SHALL load status_reg_out with the new NZCV on a clock edge when status_write_enable_in=1 and freeze=0, and SHALL otherwise hold it.
REQ-020 SHALL drive branch_address_out = pc_in + (sign_extend(signed_immediate_in) << 2), with modulo-2^32 wrap-around. branch_taken_out SHALL equal branch_taken_in, combinationally, with no added cycle.
REQ-021 SHALL, on each clock edge with freeze=0, register the ALU result, forwarded operand B (as store_value_out), dest_reg_in and the three controls, giving 1-cycle latency.
REQ-022 SHALL hold all registered outputs and the status register unchanged while freeze=1.
REQ-023 SHALL give rst priority when rst and freeze are asserted together.

Reset
REQ-024 SHALL clear all registered outputs and status_reg_out to 0 on a clock edge with rst=1.
REQ-025 SHALL discard any instruction in flight when reset is asserted mid-operation. Combinational outputs SHALL still follow their inputs during reset.

Configuration
REQ-026 SHALL honour macro EX_FORWARDING_EN. When it is defined, forwarding SHALL behave as in REQ-013.
REQ-027 SHALL, when EX_FORWARDING_EN is undefined, keep the forwarding ports, ignore them, and always use reg_file_in1 and reg_file_in2.

Verification
REQ-028 SHALL verify ADD: A=0x7FFFFFFF, imm Val2=1 with ADD and status_write_enable_in=1 -> after 1 clk, alu_result_out=0x80000000 and NZCV=1001.
REQ-029 SHALL verify SUB: A=5, Rm=5 with LSL #0 and SUB (CMP) -> result 0 and NZCV=0110.
REQ-030 SHALL verify the rotated immediate: shift_operand_in=0x4FF with MOV -> alu_result_out=0xFF000000.
REQ-031 SHALL verify the branch target: pc_in=0x100, signed_immediate_in=0xFFFFFE, branch_taken_in=1 -> branch_address_out=0xF8 in the same cycle.
REQ-032 SHALL verify freeze: hold freeze=1 for 3 cycles with changing inputs -> outputs and NZCV are unchanged. Assert rst with freeze=1 -> all outputs become 0.
REQ-033 SHALL verify forwarding: sel_src1=01, mem_fwd_value=0x10, reg_file_in1=0x99 with ADD imm 1 -> result 0x11 with EX_FORWARDING_EN defined, and 0x9A without it.

Source files
------------

// File: rtl/ex_stage_module.sv
// ex_stage_module: execute stage with forwarding muxes, shifter, ALU, NZCV register and EX/MEM register.
// Define EX_FORWARDING_EN to honour sel_src1/sel_src2; otherwise the register-file operands are always used.
module ex_stage_module (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic [31:0] pc_in,
  input  logic        mem_read_en_in,
  input  logic        mem_write_en_in,
  input  logic        wb_enable_in,
  input  logic        immediate_in,
  input  logic        branch_taken_in,
  input  logic        status_write_enable_in,
  input  logic [3:0]  execute_command_in,
  input  logic [31:0] reg_file_in1,
  input  logic [31:0] reg_file_in2,
  input  logic [3:0]  dest_reg_in,
  input  logic [23:0] signed_immediate_in,
  input  logic [11:0] shift_operand_in,
  input  logic [1:0]  sel_src1,
  input  logic [1:0]  sel_src2,
  input  logic [31:0] mem_fwd_value,
  input  logic [31:0] wb_fwd_value,
  output logic [3:0]  status_reg_out,
  output logic        branch_taken_out,
  output logic [31:0] branch_address_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] store_value_out,
  output logic [3:0]  dest_reg_out,
  output logic        mem_read_en_out,
  output logic        mem_write_en_out,
  output logic        wb_enable_out
);
  logic [31:0] w_op_a, w_op_b, w_val2, w_asr, w_b2, w_res;
  logic [63:0] w_rot_imm, w_ror;
  logic [4:0]  w_amt;
  logic [32:0] w_sum;
  logic [3:0]  w_nzcv;
  logic        w_arith, w_sub, w_cin, w_valid, w_ovf;
`ifdef EX_FORWARDING_EN
  assign w_op_a = sel_src1 == 2'b01 ? mem_fwd_value : sel_src1 == 2'b10 ? wb_fwd_value : reg_file_in1;
  assign w_op_b = sel_src2 == 2'b01 ? mem_fwd_value : sel_src2 == 2'b10 ? wb_fwd_value : reg_file_in2;
`else
  logic w_unused;
  assign w_unused = ^{sel_src1, sel_src2, mem_fwd_value, wb_fwd_value};
  assign w_op_a   = reg_file_in1;
  assign w_op_b   = reg_file_in2;
`endif
  assign w_amt     = shift_operand_in[11:7];
  assign w_rot_imm = {2{24'b0, shift_operand_in[7:0]}} >> {shift_operand_in[11:8], 1'b0};
  assign w_ror     = {w_op_b, w_op_b} >> w_amt;
  // kept as its own wire so the arithmetic shift is not turned logical by the unsigned mux context
  assign w_asr     = $signed(w_op_b) >>> w_amt;
  always_comb begin
    w_val2 = immediate_in ? w_rot_imm[31:0] :
             (mem_read_en_in || mem_write_en_in) ? {20'b0, shift_operand_in} :
             shift_operand_in[6:5] == 2'b00 ? w_op_b << w_amt :
             shift_operand_in[6:5] == 2'b01 ? w_op_b >> w_amt :
             shift_operand_in[6:5] == 2'b10 ? w_asr : w_ror[31:0];
  end
  // ADD/ADC/SUB/SBC share one adder; subtraction adds the inverted operand
  always_comb begin
    w_arith = execute_command_in inside {4'b0010, 4'b0011, 4'b0100, 4'b0101};
    w_sub   = execute_command_in inside {4'b0100, 4'b0101};
    w_valid = w_arith || execute_command_in inside {4'b0001, 4'b1001, 4'b0110, 4'b0111, 4'b1000};
    w_b2    = w_sub ? ~w_val2 : w_val2;
    w_cin   = execute_command_in == 4'b0010 ? 1'b0 : execute_command_in == 4'b0100 ? 1'b1 : status_reg_out[1];
    w_sum   = {1'b0, w_op_a} + {1'b0, w_b2} + {32'b0, w_cin};
    w_ovf   = (w_op_a[31] == w_b2[31]) && (w_sum[31] != w_op_a[31]);
    w_res   = execute_command_in == 4'b0001 ? w_val2 :
              execute_command_in == 4'b1001 ? ~w_val2 :
              w_arith ? w_sum[31:0] :
              execute_command_in == 4'b0110 ? w_op_a & w_val2 :
              execute_command_in == 4'b0111 ? w_op_a | w_val2 :
              execute_command_in == 4'b1000 ? w_op_a ^ w_val2 : 32'b0;
    w_nzcv  = !w_valid ? status_reg_out :
              {w_res[31], w_res == 32'b0, w_arith ? w_sum[32] : status_reg_out[1], w_arith ? w_ovf : status_reg_out[0]};
  end
  assign branch_taken_out   = branch_taken_in;
  assign branch_address_out = pc_in + {{6{signed_immediate_in[23]}}, signed_immediate_in, 2'b00};
  always_ff @(posedge clk) begin
    if (rst) begin
      status_reg_out   <= '0;
      alu_result_out   <= '0;
      store_value_out  <= '0;
      dest_reg_out     <= '0;
      mem_read_en_out  <= 1'b0;
      mem_write_en_out <= 1'b0;
      wb_enable_out    <= 1'b0;
    end else if (!freeze) begin
      if (status_write_enable_in) status_reg_out <= w_nzcv;
      alu_result_out   <= w_res;
      store_value_out  <= w_op_b;
      dest_reg_out     <= dest_reg_in;
      mem_read_en_out  <= mem_read_en_in;
      mem_write_en_out <= mem_write_en_in;
      wb_enable_out    <= wb_enable_in;
    end
  end
endmodule

// File: tb/tb_ex_stage_module.sv
// tb_ex_stage_module: directed vectors with hand-computed results for ex_stage_module.
module tb_ex_stage_module;
  logic        clk = 1'b0, rst, freeze;
  logic [31:0] pc_in, reg_file_in1, reg_file_in2, mem_fwd_value, wb_fwd_value;
  logic        mem_read_en_in, mem_write_en_in, wb_enable_in, immediate_in, branch_taken_in, status_write_enable_in;
  logic [3:0]  execute_command_in, dest_reg_in;
  logic [23:0] signed_immediate_in;
  logic [11:0] shift_operand_in;
  logic [1:0]  sel_src1, sel_src2;
  logic [3:0]  status_reg_out, dest_reg_out;
  logic        branch_taken_out, mem_read_en_out, mem_write_en_out, wb_enable_out;
  logic [31:0] branch_address_out, alu_result_out, store_value_out;
  int n_tests = 0, n_fail = 0;
  ex_stage_module dut (
    .clk(clk), .rst(rst), .freeze(freeze), .pc_in(pc_in),
    .mem_read_en_in(mem_read_en_in), .mem_write_en_in(mem_write_en_in), .wb_enable_in(wb_enable_in),
    .immediate_in(immediate_in), .branch_taken_in(branch_taken_in), .status_write_enable_in(status_write_enable_in),
    .execute_command_in(execute_command_in), .reg_file_in1(reg_file_in1), .reg_file_in2(reg_file_in2),
    .dest_reg_in(dest_reg_in), .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
    .sel_src1(sel_src1), .sel_src2(sel_src2), .mem_fwd_value(mem_fwd_value), .wb_fwd_value(wb_fwd_value),
    .status_reg_out(status_reg_out), .branch_taken_out(branch_taken_out), .branch_address_out(branch_address_out),
    .alu_result_out(alu_result_out), .store_value_out(store_value_out), .dest_reg_out(dest_reg_out),
    .mem_read_en_out(mem_read_en_out), .mem_write_en_out(mem_write_en_out), .wb_enable_out(wb_enable_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] cmd, input logic imm, input logic [11:0] sh,
                    input logic [31:0] r1, input logic [31:0] r2, input logic swe);
    execute_command_in = cmd; immediate_in = imm; shift_operand_in = sh;
    reg_file_in1 = r1; reg_file_in2 = r2; status_write_enable_in = swe;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, " alu"}, alu_result_out, 0);
    chk({tag, " store"}, store_value_out, 0);
    chk({tag, " ctl"}, {24'b0, dest_reg_out, 1'b0, mem_read_en_out, mem_write_en_out, wb_enable_out}, 0);
    chk({tag, " nzcv"}, {28'b0, status_reg_out}, 0);
  endtask
  initial begin
    rst = 1'b1; freeze = 1'b0; pc_in = 0; mem_fwd_value = 0; wb_fwd_value = 0;
    mem_read_en_in = 0; mem_write_en_in = 0; wb_enable_in = 1; branch_taken_in = 0;
    dest_reg_in = 4'd5; signed_immediate_in = 0; sel_src1 = 0; sel_src2 = 0;
    op(4'b0010, 1'b1, 12'h001, 32'h1234, 32'h5678, 1'b1);
    step();
    chk_all_zero("reset");
    rst = 1'b0;
    op(4'b0010, 1'b1, 12'h001, 32'h7FFFFFFF, 32'h1234, 1'b1); dest_reg_in = 4'd3;
    step();
    chk("add res", alu_result_out, 32'h80000000);
    chk("add nzcv", {28'b0, status_reg_out}, 4'b1001);
    chk("add store", store_value_out, 32'h1234);
    chk("add dest/wb", {27'b0, dest_reg_out, wb_enable_out}, {27'b0, 4'd3, 1'b1});
    op(4'b0100, 1'b0, 12'h000, 5, 5, 1'b1);
    step();
    chk("sub res", alu_result_out, 0);
    chk("sub nzcv", {28'b0, status_reg_out}, 4'b0110);
    op(4'b0001, 1'b1, 12'h4FF, 0, 0, 1'b0);
    step();
    chk("mov rotimm", alu_result_out, 32'hFF000000);
    chk("mov nzcv kept", {28'b0, status_reg_out}, 4'b0110);
    pc_in = 32'h100; signed_immediate_in = 24'hFFFFFE; branch_taken_in = 1; #1;
    chk("br addr", branch_address_out, 32'hF8);
    chk("br taken", {31'b0, branch_taken_out}, 1);
    pc_in = 0; signed_immediate_in = 24'h800000; branch_taken_in = 0; #1;
    chk("br neg max", branch_address_out, 32'hFE000000);
    chk("br not taken", {31'b0, branch_taken_out}, 0);
    pc_in = 32'hFFFFFFFC; signed_immediate_in = 24'h000001; #1;
    chk("br wrap", branch_address_out, 0);
    op(4'b0001, 1'b0, 12'h200, 0, 32'h80000013, 1'b0); step(); chk("lsl4", alu_result_out, 32'h00000130);
    op(4'b0001, 1'b0, 12'h220, 0, 32'h80000013, 1'b0); step(); chk("lsr4", alu_result_out, 32'h08000001);
    op(4'b0001, 1'b0, 12'h240, 0, 32'h80000013, 1'b0); step(); chk("asr4", alu_result_out, 32'hF8000001);
    op(4'b0001, 1'b0, 12'h260, 0, 32'h80000013, 1'b0); step(); chk("ror4", alu_result_out, 32'h38000001);
    op(4'b0001, 1'b0, 12'h040, 0, 32'h80000013, 1'b0); step(); chk("asr0", alu_result_out, 32'h80000013);
    op(4'b0010, 1'b0, 12'hABC, 32'h100, 32'h77, 1'b0); mem_read_en_in = 1;
    step();
    chk("mem off", alu_result_out, 32'hBBC);
    chk("mem rd", {31'b0, mem_read_en_out}, 1);
    mem_read_en_in = 0; mem_write_en_in = 1; op(4'b0010, 1'b0, 12'h804, 32'h10, 32'h77, 1'b0);
    step();
    chk("mem wr off", alu_result_out, 32'h814);
    chk("mem wr", {30'b0, mem_read_en_out, mem_write_en_out}, 2'b01);
    mem_write_en_in = 0;
    op(4'b1001, 1'b1, 12'h000, 0, 0, 1'b1); step();
    chk("mvn res", alu_result_out, 32'hFFFFFFFF);
    chk("mvn nzcv", {28'b0, status_reg_out}, 4'b1010);
    op(4'b0011, 1'b1, 12'h002, 1, 0, 1'b1); step();
    chk("adc res", alu_result_out, 4);
    chk("adc nzcv", {28'b0, status_reg_out}, 4'b0000);
    op(4'b0101, 1'b1, 12'h003, 5, 0, 1'b1); step();
    chk("sbc res", alu_result_out, 1);
    chk("sbc nzcv", {28'b0, status_reg_out}, 4'b0010);
    op(4'b0110, 1'b1, 12'h0FF, 32'hF0F0, 0, 1'b0); step(); chk("and", alu_result_out, 32'hF0);
    op(4'b0111, 1'b1, 12'h0FF, 32'hF0F0, 0, 1'b0); step(); chk("orr", alu_result_out, 32'hF0FF);
    op(4'b1000, 1'b1, 12'h0FF, 32'hF0F0, 0, 1'b0); step(); chk("eor", alu_result_out, 32'hF00F);
    op(4'b0000, 1'b1, 12'h0FF, 32'hF0F0, 0, 1'b1); step();
    chk("nop res", alu_result_out, 0);
    chk("nop nzcv", {28'b0, status_reg_out}, 4'b0010);
    op(4'b1111, 1'b1, 12'h000, 0, 0, 1'b1); step();
    chk("f res", alu_result_out, 0);
    chk("f nzcv", {28'b0, status_reg_out}, 4'b0010);
    op(4'b0001, 1'b1, 12'h0AB, 0, 32'h66, 1'b1); dest_reg_in = 4'd7; wb_enable_in = 1;
    step();
    chk("pre frz res", alu_result_out, 32'hAB);
    freeze = 1;
    for (int i = 0; i < 3; i++) begin
      op(4'b0100, 1'b0, 12'h000, i, i + 9, 1'b1); dest_reg_in = 4'(i + 1); wb_enable_in = i[0]; mem_read_en_in = 1;
      step();
      chk("frz res", alu_result_out, 32'hAB);
      chk("frz store", store_value_out, 32'h66);
      chk("frz ctl", {24'b0, dest_reg_out, 1'b0, mem_read_en_out, mem_write_en_out, wb_enable_out}, {24'b0, 4'd7, 4'b0001});
      chk("frz nzcv", {28'b0, status_reg_out}, 4'b0010);
    end
    rst = 1; step();
    chk_all_zero("rst+frz");
    rst = 0; freeze = 0; mem_read_en_in = 0;
    op(4'b0010, 1'b1, 12'h001, 32'h99, 32'h44, 1'b0);
    sel_src1 = 2'b01; sel_src2 = 2'b10; mem_fwd_value = 32'h10; wb_fwd_value = 32'h20;
    step();
`ifdef EX_FORWARDING_EN
    chk("fwd mem a", alu_result_out, 32'h11);
    chk("fwd wb b", store_value_out, 32'h20);
`else
    chk("nofwd a", alu_result_out, 32'h9A);
    chk("nofwd b", store_value_out, 32'h44);
`endif
    sel_src1 = 2'b10; sel_src2 = 2'b01; step();
`ifdef EX_FORWARDING_EN
    chk("fwd wb a", alu_result_out, 32'h21);
    chk("fwd mem b", store_value_out, 32'h10);
`else
    chk("nofwd a2", alu_result_out, 32'h9A);
    chk("nofwd b2", store_value_out, 32'h44);
`endif
    sel_src1 = 2'b11; sel_src2 = 2'b11; step();
    chk("sel11 a", alu_result_out, 32'h9A);
    chk("sel11 b", store_value_out, 32'h44);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
